// File: rtl/out_stream_buf.sv
// out_stream_buf
//   Result buffer between the compute core and stream_ctrl. The core fills a
//   2^ADDR_W-entry single-clock RAM. On core_done the buffer pulses get_fin to
//   start stream_ctrl. It then serves stream_v/stream_a reads, so that dst_data
//   lines up with stream_ctrl's registered dst_valid/dst_last. Core writes are
//   blocked while the frame is being read out, and any dropped write is flagged.
//
//   Optional feature macro: OUT_STREAM_BUF_CSUM_EN (adds csum/csum_v, a running
//   XOR of the streamed frame).
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : core write port
//   core_done         : one-cycle end-of-frame pulse from the core
//   buf_busy          : high while waiting for / draining a frame (WAIT, DRAIN)
//   wr_err            : sticky, set on a write or core_done while busy
//   get_fin           : one-cycle start pulse to stream_ctrl
//   stream_v/stream_a : read request from stream_ctrl
//   dst_ready/dst_valid/dst_last : sink handshake, monitored only
//   dst_data          : stream payload, one register stage after stream_v
//   csum/csum_v       : frame checksum and its strobe (macro only)
module out_stream_buf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              core_done,
    output logic              buf_busy,
    output logic              wr_err,
    output logic              get_fin,
    input  logic              stream_v,
    input  logic [ADDR_W-1:0] stream_a,
    input  logic              dst_ready,
    input  logic              dst_valid,
    input  logic              dst_last,
    output logic [DATA_W-1:0] dst_data
`ifdef OUT_STREAM_BUF_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum,
    output logic              csum_v
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT, S_DRAIN} state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic wr_ok;      // core may write this cycle
    logic drop;       // write or core_done arrived while busy
    logic beat;       // sink handshake
    logic frame_end;  // last handshake of the frame

    assign beat      = dst_valid & dst_ready;
    assign frame_end = (state == S_DRAIN) & beat & dst_last;
    assign wr_ok     = (state == S_IDLE) | (state == S_FILL);
    assign drop      = ~wr_ok & (wr_en | core_done);

    // Next-state logic. core_done takes priority in IDLE, so a frame with no
    // writes still goes through WAIT/DRAIN.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (core_done)  state_n = S_WAIT;
                else if (wr_en) state_n = S_FILL;
            end
            S_FILL:  if (core_done) state_n = S_WAIT;
            S_WAIT:  state_n = S_DRAIN;
            S_DRAIN: if (frame_end) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs. buf_busy and get_fin are registered from
    // the next state, so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            get_fin  <= 1'b0;
            buf_busy <= 1'b0;
            wr_err   <= 1'b0;
            dst_data <= '0;
        end else begin
            state    <= state_n;
            get_fin  <= (state_n == S_WAIT);
            buf_busy <= (state_n == S_WAIT) | (state_n == S_DRAIN);
            if (drop)
                wr_err <= 1'b1;
            // Read-first: a same-cycle write to stream_a is seen next read.
            // Holding when stream_v=0 covers dst_ready stalls.
            if (stream_v)
                dst_data <= mem[stream_a];
        end
    end

    // RAM write port. Contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok)
            mem[wr_addr] <= wr_data;
    end

`ifdef OUT_STREAM_BUF_CSUM_EN
    logic [DATA_W-1:0] acc;

    // The final beat is folded in directly when csum is loaded, so csum covers
    // the whole frame on the same cycle that the frame closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            csum   <= '0;
            csum_v <= 1'b0;
        end else begin
            csum_v <= 1'b0;
            if (state_n == S_WAIT && state != S_WAIT)
                acc <= '0;
            else if (state == S_DRAIN && beat)
                acc <= acc ^ dst_data;
            if (frame_end) begin
                csum   <= acc ^ dst_data;
                csum_v <= 1'b1;
            end
        end
    end
`endif

endmodule
